// File: rtl/parity_frame_pkg.sv
// ---------------------------------------------------------------------------
// parity_frame_pkg
// Shared constants for the parity frame transmitter:
//   - 3-bit FSM state encodings (IDLE/START/DATA/PARITY/STOP)
//   - DATA_W     : nibble width
//   - FRAME_BITS : serial bits per frame (start + 4 data + parity + stop)
//   - line_level : serial line value for a given state
// ---------------------------------------------------------------------------
package parity_frame_pkg;

  localparam int DATA_W     = 4;
  localparam int FRAME_BITS = 7;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // Serial line level driven while in 'state'. In DATA the line carries the
  // current LSB of the shift register; the parity bit is sent in PARITY.
  function automatic logic line_level(input logic [2:0] state,
                                      input logic       data_lsb,
                                      input logic       parity_bit);
    logic lvl;
    lvl = 1'b1;
    case (state)
      START:   lvl = 1'b0;
      DATA:    lvl = data_lsb;
      PARITY:  lvl = parity_bit;
      default: lvl = 1'b1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/parity_frame_tx_if.sv
// ---------------------------------------------------------------------------
// parity_frame_tx_if
// Valid/ready nibble handshake between a producer and parity_frame_tx.
//   in_data  : nibble to transmit (producer -> transmitter)
//   in_valid : producer has a nibble on in_data
//   in_ready : transmitter can accept a nibble
// Modports: master = producer side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface parity_frame_tx_if;
  logic [parity_frame_pkg::DATA_W-1:0] in_data;
  logic                                in_valid;
  logic                                in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/parity_frame_tx_parity_gen.sv
// ---------------------------------------------------------------------------
// nibble_parity_gen
// Combinational parity generator for one nibble.
//   data  : 4-bit nibble
//   frame : {parity, data}
// Build option: define PARITY_ODD_EN for odd parity (inverted XOR);
// otherwise parity is even (plain XOR of the data bits).
// ---------------------------------------------------------------------------
module nibble_parity_gen
  import parity_frame_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W:0]   frame
);

`ifdef PARITY_ODD_EN
  assign frame = {~(^data), data};
`else
  assign frame = {^data, data};
`endif

endmodule

// File: rtl/parity_frame_tx.sv
// ---------------------------------------------------------------------------
// parity_frame_tx
// Serial frame transmitter: accepts a nibble over a valid/ready handshake and
// shifts out start(0), 4 data bits LSB first, parity, stop(1), each bit held
// CLKS_PER_BIT clocks.
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit (>= 1)
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_if      : nibble handshake (slave modport)
//   tx_serial  : registered serial line, idles high
//   tx_busy    : high in every state except IDLE
//   frame_done : one-cycle pulse in the final cycle of STOP
// Build option: PARITY_ODD_EN selects odd parity (see nibble_parity_gen).
// ---------------------------------------------------------------------------
module parity_frame_tx
  import parity_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  parity_frame_tx_if.slave  in_if,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [2:0]        state_reg,     state_next;
  logic [CNT_W-1:0]  cnt_reg,       cnt_next;
  logic [1:0]        idx_reg,       idx_next;
  logic [DATA_W-1:0] shift_reg,     shift_next;
  logic              parity_reg,    parity_next;
  logic              tx_serial_reg, tx_serial_next;

  logic [DATA_W:0]   pg_frame;
  logic              bit_end;

  nibble_parity_gen u_parity_gen (
    .data  (in_if.in_data),
    .frame (pg_frame)
  );

  assign in_if.in_ready = (state_reg == IDLE);
  assign tx_busy        = (state_reg != IDLE);
  assign bit_end        = (cnt_reg == '0);
  assign frame_done     = (state_reg == STOP) && bit_end;
  assign tx_serial      = tx_serial_reg;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;

    // Every non-IDLE state spends CLKS_PER_BIT cycles; the counter is loaded
    // with CLKS_PER_BIT-1 on entry and the bit ends when it reaches zero.
    if (state_reg != IDLE) begin
      if (bit_end) begin
        cnt_next = CNT_LOAD;
      end else begin
        cnt_next = cnt_reg - CNT_W'(1);
      end
    end

    case (state_reg)
      IDLE: begin
        if (in_if.in_valid) begin
          state_next  = START;
          cnt_next    = CNT_LOAD;
          idx_next    = 2'd0;
          shift_next  = pg_frame[DATA_W-1:0];
          parity_next = pg_frame[DATA_W];
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (idx_reg == 2'd3) begin
            state_next = PARITY;
          end else begin
            idx_next = idx_reg + 2'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // The line register is loaded with the level of the state being entered,
    // so the line follows the state with no extra cycle of delay.
    tx_serial_next = line_level(state_next, shift_next[0], parity_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= 2'd0;
      shift_reg     <= '0;
      parity_reg    <= 1'b0;
      tx_serial_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      shift_reg     <= shift_next;
      parity_reg    <= parity_next;
      tx_serial_reg <= tx_serial_next;
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_tx
// Directed bench for parity_frame_tx. Two instances share clk/rst_n:
//   dut4 : CLKS_PER_BIT=4
//   dut1 : CLKS_PER_BIT=1
// Expected frames are written out by hand; ODD flips the parity bit when the
// design is built with PARITY_ODD_EN.
// ---------------------------------------------------------------------------
module tb_parity_frame_tx;

`ifdef PARITY_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic tx4, busy4, done4;
  logic tx1, busy1, done1;
  int   total;
  int   bad;
  int   cyc;

  parity_frame_tx_if if4 ();
  parity_frame_tx_if if1 ();

  parity_frame_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (if4.slave),
    .tx_serial  (tx4),
    .tx_busy    (busy4),
    .frame_done (done4)
  );

  parity_frame_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (if1.slave),
    .tx_serial  (tx1),
    .tx_busy    (busy1),
    .frame_done (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input bit which);
    chk({tag, " tx"},    which ? tx1 : tx4, 1'b1);
    chk({tag, " busy"},  which ? busy1 : busy4, 1'b0);
    chk({tag, " ready"}, which ? if1.in_ready : if4.in_ready, 1'b1);
    chk({tag, " done"},  which ? done1 : done4, 1'b0);
  endtask

  // Called at the falling edge inside the first START cycle. Checks every
  // cycle of the frame, then returns at the falling edge of the cycle after.
  // bits[0] is the start bit, bits[6] the stop bit.
  task automatic run_frame(input string tag, input bit which,
                           input logic [6:0] bits, input int cpb,
                           input bit drop, input int pulse_at);
    int idx;
    for (int b = 0; b < 7; b++) begin
      for (int c = 0; c < cpb; c++) begin
        idx = b * cpb + c;
        if (drop && idx == 0) begin
          if (which) if1.in_valid = 1'b0; else if4.in_valid = 1'b0;
        end
        if (pulse_at >= 0 && idx == pulse_at) begin
          if4.in_data  = 4'b1111;
          if4.in_valid = 1'b1;
          chk($sformatf("%s ready_busy", tag), if4.in_ready, 1'b0);
        end
        if (pulse_at >= 0 && idx == pulse_at + 2) if4.in_valid = 1'b0;
        chk($sformatf("%s tx b%0d c%0d", tag, b, c), which ? tx1 : tx4, bits[b]);
        chk($sformatf("%s busy b%0d c%0d", tag, b, c), which ? busy1 : busy4, 1'b1);
        chk($sformatf("%s done b%0d c%0d", tag, b, c), which ? done1 : done4,
            (b == 6 && c == cpb - 1) ? 1'b1 : 1'b0);
        @(negedge clk);
      end
    end
  endtask

  int t0;
  int t1;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    if4.in_data = 4'h0; if4.in_valid = 1'b0;
    if1.in_data = 4'h0; if1.in_valid = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_idle("reset dut4", 1'b0);
    chk_idle("reset dut1", 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset", 1'b0);

    // Single frame 1011: even parity 1
    if4.in_data = 4'b1011; if4.in_valid = 1'b1;
    @(negedge clk);
    if4.in_data = 4'b0000;   // changes after acceptance must not matter
    run_frame("f1011", 1'b0, {1'b1, 1'b1 ^ ODD, 4'b1011, 1'b0}, 4, 1'b1, -1);
    chk_idle("f1011 end", 1'b0);

    // All-zero nibble on the CLKS_PER_BIT=1 instance: even parity 0
    if1.in_data = 4'b0000; if1.in_valid = 1'b1;
    @(negedge clk);
    run_frame("f0000", 1'b1, {1'b1, 1'b0 ^ ODD, 4'b0000, 1'b0}, 1, 1'b1, -1);
    chk_idle("f0000 end", 1'b1);

    // Back-to-back with in_valid held high: 0001 (p=1) then 1110 (p=1)
    if4.in_data = 4'b0001; if4.in_valid = 1'b1;
    @(negedge clk);
    t0 = cyc;
    if4.in_data = 4'b1110;
    run_frame("b2b0001", 1'b0, {1'b1, 1'b1 ^ ODD, 4'b0001, 1'b0}, 4, 1'b0, -1);
    chk("b2b gap ready", if4.in_ready, 1'b1);
    chk("b2b gap busy", busy4, 1'b0);
    chk("b2b gap tx", tx4, 1'b1);
    @(negedge clk);
    t1 = cyc;
    chk_int("b2b start spacing", t1 - t0, 29);
    run_frame("b2b1110", 1'b0, {1'b1, 1'b1 ^ ODD, 4'b1110, 1'b0}, 4, 1'b1, -1);
    chk_idle("b2b end", 1'b0);

    // Busy ignore: 0101 (p=0), pulse 1111 during DATA bit 1
    if4.in_data = 4'b0101; if4.in_valid = 1'b1;
    @(negedge clk);
    run_frame("busy0101", 1'b0, {1'b1, 1'b0 ^ ODD, 4'b0101, 1'b0}, 4, 1'b1, 9);
    for (int i = 0; i < 8; i++) begin
      chk_idle($sformatf("busy no2nd %0d", i), 1'b0);
      @(negedge clk);
    end

    // Reset mid-frame during PARITY, then a clean 0011 frame (p=0)
    if4.in_data = 4'b0011; if4.in_valid = 1'b1;
    @(negedge clk);
    if4.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) @(negedge clk);
    chk("midrst in_parity busy", busy4, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("midrst async", 1'b0);
    @(negedge clk);
    chk_idle("midrst held", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("midrst released", 1'b0);
    if4.in_data = 4'b0011; if4.in_valid = 1'b1;
    @(negedge clk);
    run_frame("f0011", 1'b0, {1'b1, 1'b0 ^ ODD, 4'b0011, 1'b0}, 4, 1'b1, -1);
    chk_idle("f0011 end", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
